// File: rtl/rp_cs1_drive_pkg.sv
// Shared definitions for the RP drive-side CS1 register and its function sequencer:
// function codes, sequencer states, command grouping and CS1 field extraction.
package rp_cs1_drive_pkg;

    localparam logic [4:0] FUN_NOP     = 5'o00;
    localparam logic [4:0] FUN_UNLOAD  = 5'o01;
    localparam logic [4:0] FUN_SEEK    = 5'o02;
    localparam logic [4:0] FUN_RECAL   = 5'o03;
    localparam logic [4:0] FUN_DRVCLR  = 5'o04;
    localparam logic [4:0] FUN_RELEASE = 5'o05;
    localparam logic [4:0] FUN_OFFSET  = 5'o06;
    localparam logic [4:0] FUN_RTC     = 5'o07;
    localparam logic [4:0] FUN_PRESET  = 5'o10;
    localparam logic [4:0] FUN_PACKACK = 5'o11;
    localparam logic [4:0] FUN_SEARCH  = 5'o14;
    localparam logic [4:0] FUN_WRCHK   = 5'o24;
    localparam logic [4:0] FUN_WRCHKH  = 5'o25;
    localparam logic [4:0] FUN_WRITE   = 5'o30;
    localparam logic [4:0] FUN_WRHDR   = 5'o31;
    localparam logic [4:0] FUN_READ    = 5'o34;
    localparam logic [4:0] FUN_RDHDR   = 5'o35;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DECODE,
        ST_POSN,
        ST_XFER,
        ST_DONE
    } state_t;

    typedef enum logic [2:0] {
        GRP_IMM,
        GRP_POS,
        GRP_RECAL,
        GRP_XFER,
        GRP_ILL
    } fun_grp_t;

    function automatic fun_grp_t fun_group(input logic [4:0] fun);
        case (fun)
            FUN_NOP, FUN_DRVCLR, FUN_RELEASE, FUN_PRESET, FUN_PACKACK:
                return GRP_IMM;
            FUN_UNLOAD, FUN_SEEK, FUN_OFFSET, FUN_RTC, FUN_SEARCH:
                return GRP_POS;
            FUN_RECAL:
                return GRP_RECAL;
            FUN_WRCHK, FUN_WRCHKH, FUN_WRITE, FUN_WRHDR, FUN_READ, FUN_RDHDR:
                return GRP_XFER;
            default:
                return GRP_ILL;
        endcase
    endfunction

    // CS1 sits in devDATAI[20:35]; devDATAI[35] is CS1 bit 0 (GO).
    function automatic logic [4:0] cs1_fun(input logic [0:35] d);
        return d[30:34];
    endfunction

    function automatic logic cs1_go(input logic [0:35] d);
        return d[35];
    endfunction

    function automatic int unsigned timer_width(input int unsigned a, input int unsigned b);
        int unsigned m;
        int unsigned w;
        m = (a > b) ? a : b;
        w = $clog2(m);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/rp_cs1_drive_if.sv
// Massbus-side signals between the RH11 controller CS1 logic (master) and the RP drive (slave).
interface rp_cs1_drive_if;
    logic        devRESET;
    logic        rhCLR;
    logic        devLOBYTE;
    logic [0:35] devDATAI;
    logic        rpcs1WRITE;
    logic        rpATACLR;
    logic        rpXFRDONE;
    logic        rpXFRERR;
    logic        rpXFRREQ;
    logic        rpGO;
    logic [4:0]  rpFUN;
    logic        rpDVA;
    logic        rpATA;
    logic        rpERR;
    logic        rpILF;
    logic        rpRMR;

    modport master (
        output devRESET, rhCLR, devLOBYTE, devDATAI, rpcs1WRITE, rpATACLR,
               rpXFRDONE, rpXFRERR,
        input  rpXFRREQ, rpGO, rpFUN, rpDVA, rpATA, rpERR, rpILF, rpRMR
    );

    modport slave (
        input  devRESET, rhCLR, devLOBYTE, devDATAI, rpcs1WRITE, rpATACLR,
               rpXFRDONE, rpXFRERR,
        output rpXFRREQ, rpGO, rpFUN, rpDVA, rpATA, rpERR, rpILF, rpRMR
    );
endinterface

// File: rtl/rp_cs1_drive_pos_timer.sv
// Loadable down-counter timing positioning commands; it holds at zero rather than wrapping.
module rp_pos_timer #(
    parameter int unsigned WIDTH = 10
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done
);
    logic [WIDTH-1:0] r_count;

    always_ff @(posedge clk) begin
        if (!rst || i_clr) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= i_load_val;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - WIDTH'(1);
        end
    end

    assign o_done = (r_count == '0);
endmodule

// File: rtl/rp_cs1_drive.sv
// RP drive-side CS1 register: latches FUN/GO from Massbus writes and sequences the command
// through decode, positioning timeout or transfer hand-off, then drops GO.
module rp_cs1_drive
    import rp_cs1_drive_pkg::*;
#(
    parameter int unsigned POS_CYCLES   = 1000,
    parameter int unsigned RECAL_CYCLES = 4000
) (
    input logic           clk,
    input logic           rst,
    rp_cs1_drive_if.slave bus
);
    localparam int unsigned    TW         = timer_width(POS_CYCLES, RECAL_CYCLES);
    localparam logic [TW-1:0]  POS_LOAD   = TW'(POS_CYCLES - 1);
    localparam logic [TW-1:0]  RECAL_LOAD = TW'(RECAL_CYCLES - 1);

    state_t      r_state;
    logic        r_go;
    logic [4:0]  r_fun;
    logic        r_ata;
    logic        r_ilf;
    logic        r_rmr;
    logic        r_xfe;
    logic        r_xfrreq;

    fun_grp_t    w_grp;
    logic        w_clr;
    logic        w_wr;
    logic        w_tmr_load;
    logic [TW-1:0] w_tmr_val;
    logic        w_tmr_done;

    assign w_grp      = fun_group(r_fun);
    assign w_clr      = bus.devRESET | bus.rhCLR;
    assign w_wr       = bus.rpcs1WRITE & bus.devLOBYTE;
    assign w_tmr_load = (r_state == ST_DECODE) && ((w_grp == GRP_POS) || (w_grp == GRP_RECAL));
    assign w_tmr_val  = (w_grp == GRP_RECAL) ? RECAL_LOAD : POS_LOAD;

    rp_pos_timer #(.WIDTH(TW)) u_timer (
        .clk        (clk),
        .rst        (rst),
        .i_clr      (w_clr),
        .i_load     (w_tmr_load),
        .i_load_val (w_tmr_val),
        .i_dec      (r_state == ST_POSN),
        .o_done     (w_tmr_done)
    );

    always_ff @(posedge clk) begin
        if (!rst || w_clr) begin
            r_state  <= ST_IDLE;
            r_go     <= 1'b0;
            r_fun    <= '0;
            r_ata    <= 1'b0;
            r_ilf    <= 1'b0;
            r_rmr    <= 1'b0;
            r_xfe    <= 1'b0;
            r_xfrreq <= 1'b0;
        end else begin
            if (bus.rpATACLR) r_ata <= 1'b0;
            if (w_wr) begin
                if (r_go) begin
                    r_rmr <= 1'b1;
                end else begin
                    r_fun <= cs1_fun(bus.devDATAI);
                    r_go  <= cs1_go(bus.devDATAI);
                end
            end
            // ATA sets below come after the ATACLR above so that a set wins a same-edge clear.
            case (r_state)
                ST_IDLE: if (r_go) r_state <= ST_DECODE;
                ST_DECODE: begin
                    case (w_grp)
                        GRP_IMM: begin
                            r_state <= ST_DONE;
                            if (r_fun == FUN_DRVCLR) begin
                                r_ata <= 1'b0;
                                r_ilf <= 1'b0;
                                r_rmr <= 1'b0;
                                r_xfe <= 1'b0;
                            end
                        end
                        GRP_POS, GRP_RECAL: r_state <= ST_POSN;
                        GRP_XFER: begin
                            r_state  <= ST_XFER;
                            r_xfrreq <= 1'b1;
                        end
                        default: begin
                            r_state <= ST_DONE;
                            r_ilf   <= 1'b1;
                            r_ata   <= 1'b1;
                        end
                    endcase
                end
                ST_POSN: begin
                    if (w_tmr_done) begin
                        r_state <= ST_DONE;
                        r_ata   <= 1'b1;
                    end
                end
                ST_XFER: begin
                    if (bus.rpXFRDONE) begin
                        r_state  <= ST_DONE;
                        r_xfrreq <= 1'b0;
                        r_xfe    <= r_xfe | bus.rpXFRERR;
                        if (bus.rpXFRERR) r_ata <= 1'b1;
                    end
                end
                ST_DONE: begin
                    r_go    <= 1'b0;
                    r_state <= ST_IDLE;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign bus.rpXFRREQ = r_xfrreq;
    assign bus.rpGO     = r_go;
    assign bus.rpFUN    = r_fun;
    assign bus.rpDVA    = 1'b1;
    assign bus.rpATA    = r_ata;
    assign bus.rpERR    = r_ilf | r_rmr | r_xfe;
    assign bus.rpILF    = r_ilf;
    assign bus.rpRMR    = r_rmr;
endmodule
